apb_modport_slave: RTL and testbench

// - APB3 completer (slave) holding two 32-bit register banks.
// - Bank0: word indices 0..511. Bank1: word indices 512..767.
// - Connects to the slave/master-side clocking of the APB interface; every protocol monitor binds to its pins.
// - Provides programmable wait states and single-cycle error response for out-of-range accesses.

---
 rtl/apb_slave_pkg.sv | 23 ++
 rtl/apb_reg_bank.sv | 51 +++++
 rtl/apb_modport_slave.sv | 127 ++++++++++++
 tb/tb_apb_modport_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared types and memory-map constants for the APB register slave
// Purpose: bus phase enum, address/data typedefs and bank geometry defaults.
// Ports: none (package).
package apb_slave_pkg;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int APB_BANK0_BASE  = 0;
    localparam int APB_BANK0_DEPTH = 512;
    localparam int APB_BANK1_BASE  = 512;
    localparam int APB_BANK1_DEPTH = 256;
    localparam int APB_WCNT_W      = 4;

    typedef logic [APB_ADDR_W-1:0] addr_t;
    typedef logic [APB_DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - word-addressed register bank with async reset and combinational read
// Purpose: DEPTH words of storage mapped at word index BASE.
// Ports:
//   clk       in   1       write clock
//   rst_n     in   1       async active-low reset, clears every word
//   addr      in   ADDR_W  global word index
//   we        in   1       write strobe, ignored when addr is outside the bank
//   wdata     in   DATA_W  write data
//   rdata     out  DATA_W  addressed word, 0 when out of range
//   in_range  out  1       addr falls inside [BASE, BASE+DEPTH)
module apb_reg_bank
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int BASE   = 0,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              in_range
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;

    // Unsigned subtraction wraps addresses below BASE to huge values,
    // so a single compare covers both bounds.
    assign offset   = addr - ADDR_W'(BASE);
    assign in_range = (offset < ADDR_W'(DEPTH));
    assign idx      = offset[IDX_W-1:0];
    assign rdata    = in_range ? mem[idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/apb_modport_slave.sv
// rtl/apb_modport_slave.sv - APB3 completer with two register banks and programmable wait states
// Purpose: phase tracking, wait counter, bank decode, read mux and error response.
// Ports:
//   pclk      in   1       APB clock
//   preset_n  in   1       async active-low reset
//   psel      in   1       slave select
//   paddr     in   ADDR_W  word index
//   penable   in   1       access phase strobe
//   pwrite    in   1       1 = write, 0 = read
//   pwdata    in   DATA_W  write data
//   pready    out  1       transfer completes this cycle
//   prdata    out  DATA_W  read data on completing read, else 0
//   pslverr   out  1       decode error on the completing cycle
module apb_modport_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int BANK0_DEPTH = APB_BANK0_DEPTH,
    parameter int BANK1_BASE  = APB_BANK1_BASE,
    parameter int BANK1_DEPTH = APB_BANK1_DEPTH,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    // state holds the phase of the previous cycle, except that a completed
    // ACCESS is recorded as IDLE so the next selected cycle is a fresh SETUP.
    state_e                  state;
    state_e                  phase;
    logic [APB_WCNT_W-1:0]   wcnt;

    logic                    in0;
    logic                    in1;
    logic [DATA_W-1:0]       rd0;
    logic [DATA_W-1:0]       rd1;
    logic                    decode_err;
    logic                    wr_en;

    // Current bus phase. penable only counts as ACCESS when it follows a
    // SETUP or a still-waiting ACCESS; a bare penable is taken as SETUP.
    always_comb begin
        phase = IDLE;
        if (psel) begin
            if (penable && (state == SETUP || state == ACCESS)) begin
                phase = ACCESS;
            end else begin
                phase = SETUP;
            end
        end
    end

    assign pready = (phase == ACCESS) && (wcnt == APB_WCNT_W'(WAIT_STATES));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else if (pready) begin
            state <= IDLE;
        end else begin
            state <= phase;
        end
    end

    // Counts waiting ACCESS cycles; any SETUP, IDLE (psel low) or completion clears it.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wcnt <= '0;
        end else if (phase == ACCESS && !pready) begin
            wcnt <= wcnt + APB_WCNT_W'(1);
        end else begin
            wcnt <= '0;
        end
    end

    assign decode_err = !(in0 || in1);
    assign wr_en      = pready && pwrite && !decode_err;

    apb_reg_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BASE   (APB_BANK0_BASE),
        .DEPTH  (BANK0_DEPTH)
    ) u_bank0 (
        .clk      (pclk),
        .rst_n    (preset_n),
        .addr     (paddr),
        .we       (wr_en && in0),
        .wdata    (pwdata),
        .rdata    (rd0),
        .in_range (in0)
    );

    apb_reg_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BASE   (BANK1_BASE),
        .DEPTH  (BANK1_DEPTH)
    ) u_bank1 (
        .clk      (pclk),
        .rst_n    (preset_n),
        .addr     (paddr),
        .we       (wr_en && in1),
        .wdata    (pwdata),
        .rdata    (rd1),
        .in_range (in1)
    );

    always_comb begin
        prdata = '0;
        if (pready && !pwrite && !decode_err) begin
            prdata = in0 ? rd0 : rd1;
        end
    end

    assign pslverr = pready && decode_err;

endmodule

// File: tb/tb_apb_modport_slave.sv
// tb/tb_apb_modport_slave.sv - directed bench for apb_modport_slave (0 and 3 wait states)
module tb_apb_modport_slave;

    logic        pclk;
    logic        preset_n;
    logic        psel0;
    logic        psel3;
    logic [31:0] paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready0, pready3;
    logic [31:0] prdata0, prdata3;
    logic        pslverr0, pslverr3;

    int checks = 0;
    int passes = 0;

    apb_modport_slave #(.WAIT_STATES(0)) u_dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel0),
        .paddr    (paddr),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready0),
        .prdata   (prdata0),
        .pslverr  (pslverr0)
    );

    apb_modport_slave #(.WAIT_STATES(3)) u_dut_ws (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel3),
        .paddr    (paddr),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready3),
        .prdata   (prdata3),
        .pslverr  (pslverr3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    function automatic logic cur_pready(input bit ws);
        return ws ? pready3 : pready0;
    endfunction

    function automatic logic [31:0] cur_prdata(input bit ws);
        return ws ? prdata3 : prdata0;
    endfunction

    function automatic logic cur_pslverr(input bit ws);
        return ws ? pslverr3 : pslverr0;
    endfunction

    task automatic set_sel(input bit ws, input logic v);
        if (ws) psel3 = v;
        else    psel0 = v;
    endtask

    // Full SETUP + ACCESS transfer; returns data/error at the completing cycle
    // and the number of ACCESS cycles spent with pready low.
    task automatic xfer(input bit ws, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int waits, output bit to);
        @(negedge pclk);
        set_sel(ws, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        to      = 1'b0;
        #1;
        while (!cur_pready(ws)) begin
            waits++;
            if (waits > 20) begin
                to = 1'b1;
                break;
            end
            @(negedge pclk);
            #1;
        end
        rd = cur_prdata(ws);
        er = cur_pslverr(ws);
        @(negedge pclk);
        set_sel(ws, 1'b0);
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          waits;
    bit          to;
    int          n;

    initial begin
        vecs[0]  = '{1'b0, 32'd5,   32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h10,  32'hDEADBEEF,  32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h10,  32'h0,         32'hDEADBEEF,  1'b0};
        vecs[3]  = '{1'b1, 32'd511, 32'hA5A50001,  32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'd767, 32'hA5A50002,  32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'd511, 32'h0,         32'hA5A50001,  1'b0};
        vecs[6]  = '{1'b0, 32'd767, 32'h0,         32'hA5A50002,  1'b0};
        vecs[7]  = '{1'b1, 32'd768, 32'h1234,      32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'd768, 32'h0,         32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'd767, 32'h0,         32'hA5A50002,  1'b0};
        vecs[10] = '{1'b1, 32'd512, 32'h00000055,  32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'd512, 32'h0,         32'h00000055,  1'b0};
        vecs[12] = '{1'b0, 32'd0,   32'h0,         32'h0,         1'b0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFF, 32'h0,   32'h0,         1'b1};

        // Reset held with an active-looking bus: outputs must stay quiet.
        preset_n = 1'b0;
        psel0    = 1'b1;
        psel3    = 1'b1;
        penable  = 1'b1;
        pwrite   = 1'b0;
        paddr    = 32'd5;
        pwdata   = 32'h0;
        repeat (3) @(negedge pclk);
        #1;
        chk("reset_pready",  {31'b0, pready0},  32'd0);
        chk("reset_pslverr", {31'b0, pslverr0}, 32'd0);
        chk("reset_prdata",  prdata0,           32'd0);
        chk("reset_pready_ws", {31'b0, pready3}, 32'd0);
        psel0    = 1'b0;
        psel3    = 1'b0;
        penable  = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, waits, to);
            chk($sformatf("vec%0d_timeout", i), {31'b0, to}, 32'd0);
            chk($sformatf("vec%0d_waits", i), waits, 32'd0);
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            #1;
            chk($sformatf("vec%0d_pslverr_after", i), {31'b0, pslverr0}, 32'd0);
        end

        // Three wait states: write then read back, counting low-pready ACCESS cycles.
        xfer(1'b1, 1'b1, 32'd7, 32'h00000077, rd, er, waits, to);
        chk("ws3_write_waits", waits, 32'd3);
        @(negedge pclk);
        psel3   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd7;
        #1;
        chk("ws3_setup_pready", {31'b0, pready3}, 32'd0);
        @(negedge pclk);
        penable = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (!pready3) n++;
            @(negedge pclk);
        end
        #1;
        chk("ws3_low_cycles", n, 32'd3);
        chk("ws3_pready_4th", {31'b0, pready3}, 32'd1);
        chk("ws3_prdata", prdata3, 32'h00000077);
        @(negedge pclk);
        psel3   = 1'b0;
        penable = 1'b0;

        // psel dropped during a wait-state ACCESS: no write may land.
        @(negedge pclk);
        psel3   = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h30;
        pwdata  = 32'h00000BAD;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel3   = 1'b0;
        penable = 1'b0;
        xfer(1'b1, 1'b0, 32'h30, 32'h0, rd, er, waits, to);
        chk("abort_no_write", rd, 32'h0);

        // Back-to-back: errored write followed directly by a SETUP; pslverr must drop.
        @(negedge pclk);
        psel0   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'd1000;
        pwdata  = 32'hFFFF0000;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        chk("b2b_err", {31'b0, pslverr0}, 32'd1);
        @(negedge pclk);
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h10;
        #1;
        chk("b2b_setup_pslverr", {31'b0, pslverr0}, 32'd0);
        chk("b2b_setup_pready", {31'b0, pready0}, 32'd0);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        chk("b2b_read", prdata0, 32'hDEADBEEF);
        @(negedge pclk);
        psel0   = 1'b0;
        penable = 1'b0;

        // penable without a preceding SETUP is itself a SETUP.
        @(negedge pclk);
        psel0   = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'd511;
        #1;
        chk("bare_penable_pready", {31'b0, pready0}, 32'd0);
        @(negedge pclk);
        #1;
        chk("bare_penable_then_done", {31'b0, pready0}, 32'd1);
        chk("bare_penable_prdata", prdata0, 32'hA5A50001);
        @(negedge pclk);
        psel0   = 1'b0;
        penable = 1'b0;

        // Async reset during the completing ACCESS of a write to 0x20.
        @(negedge pclk);
        psel0   = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h20;
        pwdata  = 32'hCAFEF00D;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        preset_n = 1'b0;
        #1;
        chk("rst_mid_pready", {31'b0, pready0}, 32'd0);
        chk("rst_mid_prdata", prdata0, 32'd0);
        @(negedge pclk);
        psel0   = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        xfer(1'b0, 1'b0, 32'h20, 32'h0, rd, er, waits, to);
        chk("rst_mid_no_write", rd, 32'h0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, er, waits, to);
        chk("rst_clears_bank0", rd, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
